mc_seq_ctrl: RTL and testbench
==============================

Name: mc_seq_ctrl

Overview:
- Multi-cycle sequencing controller for the PC register (clk/reset/En/npc) and the surrounding single-issue MIPS datapath.
- Walks each instruction through IF/ID/EXE/MEM/WB.
- Gates the PC enable so PC updates exactly once per instruction, in the instruction's final cycle. Selects the npc source in that same cycle.
- Handshakes with instruction and data memories through ready inputs. Keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr  in  32  IR output (stable from ID onward)
zero  in  1  ALU equality flag, valid in EXE
im_rdy  in  1  instruction memory data valid
dm_rdy  in  1  data memory access complete
pc_en  out  1  drives PC register En
npc_sel  out  2  0=PC+4, 1=PC+4+(imm<<2), 2=j/jal target, 3=GRF[rs]
ir_en  out  1  IR load enable
grf_we  out  1  register file write enable
a3_sel  out  2  0=rt, 1=rd, 2=$31
wd_sel  out  2  0=ALU, 1=DM, 2=PC+4
alu_op  out  3  0=add, 1=sub, 2=or, 3=lui (B<<16)
alu_b_sel  out  1  0=GRF[rt], 1=extended imm
ext_op  out  1  0=zero-ext, 1=sign-ext
dm_we  out  1  data memory write enable
state  out  3  current state (debug)
retired  out  CNT_W  count of pc_en pulses since reset

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4. Values 5-7 are illegal and go to IF next cycle with all enables 0.
- Outputs are combinational from the state register and instr[31:26]/instr[5:0]. state and retired are registers.
- Reset: state<=IF and retired<=0 on the clk edge with reset=1. While reset=1, pc_en, ir_en, grf_we and dm_we are forced to 0. Reset mid-instruction aborts it with no PC update.
- IF: ir_en=im_rdy. Stay in IF while im_rdy=0. When im_rdy=1, go to ID. pc_en=0 in IF.
- Decode, opcode/funct:
  - addu: 000000/100001
  - subu: 000000/100011
  - jr: 000000/001000
  - ori: 001101
  - lw: 100011
  - sw: 101011
  - beq: 000100
  - lui: 001111
  - j: 000010
  - jal: 000011
  - Anything else, including all-zero nop, is unsupported.
- Sequences. The final state asserts pc_en=1 for one cycle, then goes to IF.
  - addu/subu: IF,ID,EXE,WB. alu_op add/sub, alu_b_sel=0. WB: grf_we=1, a3_sel=1, wd_sel=0, npc_sel=0.
  - ori/lui: IF,ID,EXE,WB. alu_b_sel=1, ext_op=0, alu_op or/lui. WB: a3_sel=0, wd_sel=0.
  - lw: IF,ID,EXE,MEM,WB. ext_op=1, add. MEM holds until dm_rdy=1. WB: a3_sel=0, wd_sel=1.
  - sw: IF,ID,EXE,MEM. dm_we=1 every MEM cycle until dm_rdy=1. pc_en=dm_rdy with npc_sel=0. MEM is final.
  - beq: IF,ID,EXE. alu_op=sub. EXE is final, npc_sel = zero ? 1 : 0.
  - j: IF,ID. ID is final, npc_sel=2.
  - jr: IF,ID. ID is final, npc_sel=3.
  - jal: IF,ID,WB. WB: grf_we=1, a3_sel=2, wd_sel=2, npc_sel=2.
  - unsupported: IF,ID. ID is final, npc_sel=0, no writes.
- grf_we and dm_we are never 1 outside the states listed above.
- pc_en is asserted in exactly one cycle per instruction, never in IF.
- Default values for unlisted outputs in any state: 0.
- retired increments by 1 in each cycle with pc_en=1 and reset=0. It wraps modulo 2^CNT_W.

Test Plan:
- reset=1 for 2 cycles, then im_rdy=1, instr=0x00851021 (addu $2,$4,$5) -> state 0,1,2,4,0. grf_we=1 and pc_en=1 only in cycle 4 (a3_sel=1). retired=1.
- lw 0x8C820004 with dm_rdy held 0 for 3 MEM cycles, then 1 -> state stays 3 for 4 cycles. WB: grf_we=1, wd_sel=1. PC enabled only in WB.
- beq 0x10850003 with zero=1, then the same word with zero=0 -> EXE: pc_en=1 with npc_sel=1, then npc_sel=0. Instruction length 3 cycles. grf_we=0 throughout.
- jal 0x0C000C00 -> ID then WB. WB: grf_we=1, a3_sel=2, wd_sel=2, npc_sel=2, pc_en=1. j 0x08000C00 -> pc_en in ID with npc_sel=2.
- sw 0xAC820008, dm_rdy=0 for 2 MEM cycles -> dm_we=1 for 3 cycles. pc_en=1 only in the third. Assert reset during the second MEM cycle -> next state IF, pc_en never asserted, retired unchanged.
- unsupported 0x00000000, then im_rdy=0 for 5 cycles -> ID: pc_en=1, npc_sel=0, no writes. IF held 5 cycles with ir_en=0. With CNT_W=4, 17 instructions -> retired=1.

Source files
------------

// File: rtl/mc_seq_ctrl.sv
// mc_seq_ctrl -- multi-cycle sequencing controller for a single-issue MIPS
// datapath. Each instruction is walked through IF/ID/EXE/MEM/WB. The PC
// register enable is pulsed exactly once per instruction, in that
// instruction's final cycle, together with the matching npc source select.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   instr      IR output, stable from ID onward
//   zero       ALU equality flag, meaningful in EXE
//   im_rdy     instruction memory data valid
//   dm_rdy     data memory access complete
//   pc_en      PC register enable (one pulse per instruction)
//   npc_sel    0=PC+4, 1=PC+4+(imm<<2), 2=j/jal target, 3=GRF[rs]
//   ir_en      IR load enable
//   grf_we     register file write enable
//   a3_sel     write register select: 0=rt, 1=rd, 2=$31
//   wd_sel     write data select: 0=ALU, 1=DM, 2=PC+4
//   alu_op     0=add, 1=sub, 2=or, 3=lui
//   alu_b_sel  ALU B operand: 0=GRF[rt], 1=extended imm
//   ext_op     immediate extension: 0=zero, 1=sign
//   dm_we      data memory write enable
//   state      current state register (debug)
//   retired    number of pc_en pulses since reset, wraps modulo 2^CNT_W

module mc_seq_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             im_rdy,
  input  logic             dm_rdy,
  output logic             pc_en,
  output logic [1:0]       npc_sel,
  output logic             ir_en,
  output logic             grf_we,
  output logic [1:0]       a3_sel,
  output logic [1:0]       wd_sel,
  output logic [2:0]       alu_op,
  output logic             alu_b_sel,
  output logic             ext_op,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW,
    C_BEQ, C_LUI, C_J, C_JAL, C_UNSUP
  } instrClass_t;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  instrClass_t     instrClass;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unusedInstrBits;

  logic pcEnRaw, irEnRaw, grfWeRaw, dmWeRaw;

  assign opcode          = instr[31:26];
  assign funct           = instr[5:0];
  assign unusedInstrBits = ^instr[25:6];

  // Instruction decode: only opcode and funct matter. Any R-type funct that
  // is not addu/subu/jr, and any unknown opcode, falls into the unsupported
  // class, which retires from ID as a plain PC+4 step with no side effects.
  always_comb begin
    instrClass = C_UNSUP;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100001: instrClass = C_ADDU;
          6'b100011: instrClass = C_SUBU;
          6'b001000: instrClass = C_JR;
          default:   instrClass = C_UNSUP;
        endcase
      end
      6'b001101: instrClass = C_ORI;
      6'b100011: instrClass = C_LW;
      6'b101011: instrClass = C_SW;
      6'b000100: instrClass = C_BEQ;
      6'b001111: instrClass = C_LUI;
      6'b000010: instrClass = C_J;
      6'b000011: instrClass = C_JAL;
      default:   instrClass = C_UNSUP;
    endcase
  end

  // Next-state and control outputs. Everything defaults to 0 and the
  // default next state is IF, so illegal state encodings recover in one
  // cycle with every enable low. The ALU controls are held through MEM for
  // loads and stores so the address stays stable during the access.
  always_comb begin
    state_d   = S_IF;
    pcEnRaw   = 1'b0;
    npc_sel   = 2'd0;
    irEnRaw   = 1'b0;
    grfWeRaw  = 1'b0;
    a3_sel    = 2'd0;
    wd_sel    = 2'd0;
    alu_op    = 3'd0;
    alu_b_sel = 1'b0;
    ext_op    = 1'b0;
    dmWeRaw   = 1'b0;

    case (state_q)
      S_IF: begin
        irEnRaw = im_rdy;
        state_d = im_rdy ? S_ID : S_IF;
      end

      S_ID: begin
        case (instrClass)
          C_J: begin
            pcEnRaw = 1'b1;
            npc_sel = 2'd2;
            state_d = S_IF;
          end
          C_JR: begin
            pcEnRaw = 1'b1;
            npc_sel = 2'd3;
            state_d = S_IF;
          end
          C_UNSUP: begin
            pcEnRaw = 1'b1;
            state_d = S_IF;
          end
          C_JAL:   state_d = S_WB;
          default: state_d = S_EXE;
        endcase
      end

      S_EXE, S_MEM: begin
        case (instrClass)
          C_SUBU: alu_op = 3'd1;
          C_BEQ:  alu_op = 3'd1;
          C_ORI:  alu_op = 3'd2;
          C_LUI:  alu_op = 3'd3;
          default: alu_op = 3'd0;
        endcase
        alu_b_sel = (instrClass == C_ORI) || (instrClass == C_LUI) ||
                    (instrClass == C_LW)  || (instrClass == C_SW);
        ext_op    = (instrClass == C_LW) || (instrClass == C_SW) ||
                    (instrClass == C_BEQ);

        if (state_q == S_EXE) begin
          case (instrClass)
            C_BEQ: begin
              pcEnRaw = 1'b1;
              npc_sel = zero ? 2'd1 : 2'd0;
              state_d = S_IF;
            end
            C_LW, C_SW: state_d = S_MEM;
            C_ADDU, C_SUBU, C_ORI, C_LUI: state_d = S_WB;
            default: state_d = S_IF;
          endcase
        end else begin
          // A store retires in the same cycle the memory acknowledges it.
          if (instrClass == C_SW) begin
            dmWeRaw = 1'b1;
            pcEnRaw = dm_rdy;
            state_d = dm_rdy ? S_IF : S_MEM;
          end else if (instrClass == C_LW) begin
            state_d = dm_rdy ? S_WB : S_MEM;
          end else begin
            state_d = S_IF;
          end
        end
      end

      S_WB: begin
        grfWeRaw = 1'b1;
        pcEnRaw  = 1'b1;
        state_d  = S_IF;
        case (instrClass)
          C_ADDU, C_SUBU: a3_sel = 2'd1;
          C_JAL: begin
            a3_sel  = 2'd2;
            wd_sel  = 2'd2;
            npc_sel = 2'd2;
          end
          C_LW:    wd_sel = 2'd1;
          default: a3_sel = 2'd0;
        endcase
      end

      default: state_d = S_IF;
    endcase
  end

  // Reset masks every enable so an instruction aborted by reset leaves no
  // architectural side effects.
  assign pc_en  = pcEnRaw  & ~reset;
  assign ir_en  = irEnRaw  & ~reset;
  assign grf_we = grfWeRaw & ~reset;
  assign dm_we  = dmWeRaw  & ~reset;

  // State register and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (pc_en) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign state   = state_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// tb_mc_seq_ctrl -- scoreboard bench for mc_seq_ctrl. The stimulus process
// plays whole instructions (with IF/MEM wait states and occasional reset
// aborts), derives each cycle's expected outputs from a per-class sequence
// table, and queues them; a negedge monitor pops and compares.

module tb_mc_seq_ctrl;

  localparam int CNT_W = 4;

  localparam int ST_IF  = 0;
  localparam int ST_ID  = 1;
  localparam int ST_EXE = 2;
  localparam int ST_MEM = 3;
  localparam int ST_WB  = 4;

  localparam int K_ADDU  = 0;
  localparam int K_SUBU  = 1;
  localparam int K_JR    = 2;
  localparam int K_ORI   = 3;
  localparam int K_LW    = 4;
  localparam int K_SW    = 5;
  localparam int K_BEQ   = 6;
  localparam int K_LUI   = 7;
  localparam int K_J     = 8;
  localparam int K_JAL   = 9;
  localparam int K_UNSUP = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      instr;
  logic             zero;
  logic             im_rdy;
  logic             dm_rdy;
  logic             pc_en;
  logic [1:0]       npc_sel;
  logic             ir_en;
  logic             grf_we;
  logic [1:0]       a3_sel;
  logic [1:0]       wd_sel;
  logic [2:0]       alu_op;
  logic             alu_b_sel;
  logic             ext_op;
  logic             dm_we;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  typedef struct packed {
    logic [2:0]       st;
    logic             pcEn;
    logic [1:0]       npc;
    logic             irEn;
    logic             grfWe;
    logic             dmWe;
    logic [1:0]       a3;
    logic [1:0]       wd;
    logic             aluCare;
    logic [2:0]       alu;
    logic             bCare;
    logic             bSel;
    logic             extCare;
    logic             ext;
    logic [CNT_W-1:0] ret;
  } expT;

  expT              expQ[$];
  int               numChecks = 0;
  int               numErrors = 0;
  logic [CNT_W-1:0] modelRetired = '0;

  always #5 clk = ~clk;

  mc_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .im_rdy    (im_rdy),
    .dm_rdy    (dm_rdy),
    .pc_en     (pc_en),
    .npc_sel   (npc_sel),
    .ir_en     (ir_en),
    .grf_we    (grf_we),
    .a3_sel    (a3_sel),
    .wd_sel    (wd_sel),
    .alu_op    (alu_op),
    .alu_b_sel (alu_b_sel),
    .ext_op    (ext_op),
    .dm_we     (dm_we),
    .state     (state),
    .retired   (retired)
  );

  // Reference decode table: opcode, then funct for R-type.
  function automatic int classify(input logic [31:0] w);
    case (w[31:26])
      6'b000000: begin
        if (w[5:0] == 6'b100001) return K_ADDU;
        if (w[5:0] == 6'b100011) return K_SUBU;
        if (w[5:0] == 6'b001000) return K_JR;
        return K_UNSUP;
      end
      6'b001101: return K_ORI;
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b001111: return K_LUI;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      default:   return K_UNSUP;
    endcase
  endfunction

  function automatic expT blankExp();
    expT e;
    e = '0;
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:  begin w[31:26] = 6'b000000; w[5:0] = 6'b100001; end
      1:  begin w[31:26] = 6'b000000; w[5:0] = 6'b100011; end
      2:  begin w[31:26] = 6'b000000; w[5:0] = 6'b001000; end
      3:  w[31:26] = 6'b001101;
      4:  w[31:26] = 6'b100011;
      5:  w[31:26] = 6'b101011;
      6:  w[31:26] = 6'b000100;
      7:  w[31:26] = 6'b001111;
      8:  w[31:26] = 6'b000010;
      9:  w[31:26] = 6'b000011;
      10: w[31:26] = 6'b000000;
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkField(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic checkOutput(input expT e);
    checkField("state",   {29'd0, state},  {29'd0, e.st});
    checkField("pc_en",   {31'd0, pc_en},  {31'd0, e.pcEn});
    checkField("ir_en",   {31'd0, ir_en},  {31'd0, e.irEn});
    checkField("grf_we",  {31'd0, grf_we}, {31'd0, e.grfWe});
    checkField("dm_we",   {31'd0, dm_we},  {31'd0, e.dmWe});
    checkField("retired", 32'(retired),    32'(e.ret));
    if (e.pcEn) checkField("npc_sel", {30'd0, npc_sel}, {30'd0, e.npc});
    if (e.grfWe) begin
      checkField("a3_sel", {30'd0, a3_sel}, {30'd0, e.a3});
      checkField("wd_sel", {30'd0, wd_sel}, {30'd0, e.wd});
    end
    if (e.aluCare) checkField("alu_op",    {29'd0, alu_op},    {29'd0, e.alu});
    if (e.bCare)   checkField("alu_b_sel", {31'd0, alu_b_sel}, {31'd0, e.bSel});
    if (e.extCare) checkField("ext_op",    {31'd0, ext_op},    {31'd0, e.ext});
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(expQ.pop_front());
  end

  // Drive one cycle of inputs, queue its expectation, and advance the
  // counter model across the clock edge.
  task automatic applyStimulus(input logic rst, input logic imR, input logic dmR,
                               input logic z, input expT e);
    reset  = rst;
    im_rdy = imR;
    dm_rdy = dmR;
    zero   = z;
    e.ret  = modelRetired;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (rst) modelRetired = '0;
    else if (e.pcEn) modelRetired = modelRetired + 1'b1;
  endtask

  // Plays one instruction. nIf/nMem are wait cycles in IF/MEM; rstAt is the
  // cycle (counted from the first IF cycle) at which reset aborts it, or -1;
  // zeroFix forces the zero flag (-1 = random every cycle).
  task automatic runInstr(input logic [31:0] w, input int nIf, input int nMem,
                          input int rstAt, input int zeroFix);
    int   cls;
    int   seq[$];
    int   cyc;
    int   reps;
    logic imR, dmR, z, lastPhase;
    expT  e;

    cls = classify(w);
    case (cls)
      K_ADDU, K_SUBU, K_ORI, K_LUI: seq = '{ST_ID, ST_EXE, ST_WB};
      K_LW:  seq = '{ST_ID, ST_EXE, ST_MEM, ST_WB};
      K_SW:  seq = '{ST_ID, ST_EXE, ST_MEM};
      K_BEQ: seq = '{ST_ID, ST_EXE};
      K_JAL: seq = '{ST_ID, ST_WB};
      default: seq = '{ST_ID};
    endcase

    instr = w;
    cyc   = 0;
    for (int i = 0; i <= nIf; i++) begin
      imR    = (i == nIf);
      e      = blankExp();
      e.st   = ST_IF[2:0];
      e.irEn = imR;
      if (cyc == rstAt) begin
        e.irEn = 1'b0;
        applyStimulus(1'b1, imR, 1'($urandom), 1'($urandom), e);
        return;
      end
      applyStimulus(1'b0, imR, 1'($urandom), 1'($urandom), e);
      cyc++;
    end

    for (int p = 0; p < seq.size(); p++) begin
      lastPhase = (p == seq.size() - 1);
      reps = (seq[p] == ST_MEM) ? nMem + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        imR = 1'($urandom);
        dmR = (seq[p] == ST_MEM) ? (r == reps - 1) : 1'($urandom);
        z   = (zeroFix < 0) ? 1'($urandom) : 1'(zeroFix);
        e   = blankExp();
        e.st    = seq[p][2:0];
        e.pcEn  = lastPhase && (seq[p] != ST_MEM || dmR);
        e.npc   = (cls == K_J || cls == K_JAL) ? 2'd2 :
                  (cls == K_JR)                ? 2'd3 :
                  (cls == K_BEQ && z)          ? 2'd1 : 2'd0;
        e.grfWe = (seq[p] == ST_WB);
        e.dmWe  = (seq[p] == ST_MEM) && (cls == K_SW);
        e.a3    = (cls == K_ADDU || cls == K_SUBU) ? 2'd1 :
                  (cls == K_JAL)                   ? 2'd2 : 2'd0;
        e.wd    = (cls == K_LW) ? 2'd1 : (cls == K_JAL) ? 2'd2 : 2'd0;
        if (seq[p] == ST_EXE) begin
          e.aluCare = (cls != K_SW);
          e.alu     = (cls == K_SUBU || cls == K_BEQ) ? 3'd1 :
                      (cls == K_ORI) ? 3'd2 : (cls == K_LUI) ? 3'd3 : 3'd0;
          e.bCare   = (cls == K_ADDU || cls == K_SUBU || cls == K_ORI || cls == K_LUI);
          e.bSel    = (cls == K_ORI || cls == K_LUI);
          e.extCare = (cls == K_ORI || cls == K_LUI || cls == K_LW);
          e.ext     = (cls == K_LW);
        end
        if (cyc == rstAt) begin
          e.pcEn  = 1'b0;
          e.grfWe = 1'b0;
          e.dmWe  = 1'b0;
          applyStimulus(1'b1, imR, dmR, z, e);
          return;
        end
        applyStimulus(1'b0, imR, dmR, z, e);
        cyc++;
      end
    end
  endtask

  initial begin
    expT e;
    int  rstAt;

    reset  = 1'b1;
    instr  = 32'h0;
    zero   = 1'b0;
    im_rdy = 1'b0;
    dm_rdy = 1'b0;
    @(posedge clk);
    #1;
    // Second reset cycle: state already IF, counter cleared, enables low.
    e    = blankExp();
    e.st = ST_IF[2:0];
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, e);

    runInstr(32'h00851021, 0, 0, -1, -1);  // addu
    runInstr(32'h8C820004, 0, 3, -1, -1);  // lw, 3 MEM waits
    runInstr(32'h10850003, 0, 0, -1, 1);   // beq taken
    runInstr(32'h10850003, 0, 0, -1, 0);   // beq not taken
    runInstr(32'h0C000C00, 0, 0, -1, -1);  // jal
    runInstr(32'h08000C00, 0, 0, -1, -1);  // j
    runInstr(32'h00800008, 1, 0, -1, -1);  // jr
    runInstr(32'h3485FFFF, 0, 0, -1, -1);  // ori
    runInstr(32'h3C051234, 0, 0, -1, -1);  // lui
    runInstr(32'h00851023, 0, 0, -1, -1);  // subu
    runInstr(32'hAC820008, 0, 2, -1, -1);  // sw, 2 MEM waits
    runInstr(32'hAC820008, 0, 2, 4, -1);   // sw, reset in second MEM cycle
    runInstr(32'h00000000, 0, 0, -1, -1);  // unsupported nop
    runInstr(32'h00000000, 5, 0, -1, -1);  // IF held 5 cycles
    for (int i = 0; i < 17; i++) runInstr(32'h00000000, 0, 0, -1, -1);

    for (int i = 0; i < 300; i++) begin
      rstAt = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      runInstr(randInstr(), $urandom_range(0, 3), $urandom_range(0, 3), rstAt, -1);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
